// File: rtl/gpio_pkg.sv
// Shared constants, types and address helpers for the GPIO pin stage.
package gpio_pkg;
  localparam int GPIO_W   = 34;
  localparam int W0_WIDTH = 24;
  localparam int W1_WIDTH = 10;
  localparam int BUS_W    = 32;

  localparam logic [13:0] PORT_BASE = 14'h1000;
  localparam logic [13:0] DDR_BASE  = 14'h1100;
  localparam logic [13:0] OD_BASE   = 14'h1300;
  localparam logic [13:0] CHG_BASE  = 14'h1400;

  typedef logic [GPIO_W-1:0] gpio_vec_t;
  typedef enum logic [2:0] {BK_NONE, BK_PORT, BK_DDR, BK_OD, BK_CHG} bank_e;

  // Banks are 256 bytes apart, so the bank is the word address above the low 6 bits.
  function automatic bank_e bank_of(input logic [11:0] waddr);
    logic [5:0] b;
    b = waddr[11:6];
    if (b == PORT_BASE[13:8]) return BK_PORT;
    if (b == DDR_BASE[13:8])  return BK_DDR;
    if (b == OD_BASE[13:8])   return BK_OD;
    if (b == CHG_BASE[13:8])  return BK_CHG;
    return BK_NONE;
  endfunction

  function automatic gpio_vec_t vec_of_word(input logic [W0_WIDTH-1:0] d, input logic hi);
    gpio_vec_t v;
    v = '0;
    if (hi) v[GPIO_W-1:W0_WIDTH] = d[W1_WIDTH-1:0];
    else    v[W0_WIDTH-1:0]      = d;
    return v;
  endfunction

  function automatic logic [BUS_W-1:0] word_of_vec(input gpio_vec_t v, input logic hi);
    logic [BUS_W-1:0] w;
    w = '0;
    if (hi) w[W1_WIDTH-1:0] = v[GPIO_W-1:W0_WIDTH];
    else    w[W0_WIDTH-1:0] = v[W0_WIDTH-1:0];
    return w;
  endfunction
endpackage

// File: rtl/gpio_sync2.sv
// Parameterized-width two-flop synchronizer for asynchronous pad inputs.
module gpio_sync2 #(
  parameter int Width = 1
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic [Width-1:0] d_i,
  output logic [Width-1:0] q_o
);
  logic [Width-1:0] s1_q, s2_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      s1_q <= '0;
      s2_q <= '0;
    end else begin
      s1_q <= d_i;
      s2_q <= s1_q;
    end
  end

  assign q_o = s2_q;
endmodule

// File: rtl/gpio_pin_io_reg.sv
// GPIO pin stage: open-drain pad drive, synchronized pin sampling, pipelined register reads.
// Optional pin-change status/irq is enabled with `define GPIO_CHANGE_IRQ_EN.
module gpio_pin_io_reg
  import gpio_pkg::*;
#(
  parameter int AddrWidth      = 14,
  parameter int BusWidth       = BUS_W,
  parameter int MuxGPIOIOWidth = GPIO_W,
  parameter int NumIOReg       = 6
) (
  input  logic                      CLOCK,
  input  logic                      reset_reg_N,
  input  logic                      write_reg,
  input  logic                      read_reg,
  input  logic [AddrWidth-3:0]      busaddress,
  input  logic [BusWidth-1:0]       busdata_in,
  output logic [BusWidth-1:0]       busdata_out,
  output logic                      read_valid,
  input  logic [MuxGPIOIOWidth-1:0] oe,
  input  logic [MuxGPIOIOWidth-1:0] iodatafromhm3,
  input  logic [MuxGPIOIOWidth-1:0] pin_in,
  output logic [MuxGPIOIOWidth-1:0] pin_out,
  output logic [MuxGPIOIOWidth-1:0] pin_oe,
  output logic                      irq
);
  gpio_vec_t                 port_s2, od_q, od_d, wr_vec, wr_mask, rd_vec, chg_vec;
  logic                      wr_hit;
  bank_e                     wr_bank;
  logic [1:0]                vld_pipe_q;
  logic [AddrWidth-3:0]      rd_addr_q;
  logic [BusWidth-1:0]       rdata, busdata_out_q;
  logic [MuxGPIOIOWidth-1:0] pin_out_q, pin_oe_q;
  logic                      unused_hi;

  // Only the first two words of each bank's window carry state.
  function automatic logic word_hit(input logic [AddrWidth-3:0] a);
    return (a[5:0] < 6'(NumIOReg)) && (a[5:1] == 5'd0);
  endfunction

  gpio_sync2 #(.Width(MuxGPIOIOWidth)) u_sync (
    .clk_i  (CLOCK),
    .rst_ni (reset_reg_N),
    .d_i    (pin_in),
    .q_o    (port_s2)
  );

  assign unused_hi = ^busdata_in[BusWidth-1:W0_WIDTH];
  assign wr_bank   = bank_of(busaddress);
  assign wr_hit    = write_reg && word_hit(busaddress);
  assign wr_vec    = vec_of_word(busdata_in[W0_WIDTH-1:0], busaddress[0]);
  assign wr_mask   = vec_of_word('1, busaddress[0]);
  assign od_d      = (wr_hit && wr_bank == BK_OD) ? ((od_q & ~wr_mask) | wr_vec) : od_q;

  always_ff @(posedge CLOCK or negedge reset_reg_N) begin
    if (!reset_reg_N) begin
      od_q          <= '0;
      pin_out_q     <= '0;
      pin_oe_q      <= '0;
      vld_pipe_q    <= '0;
      rd_addr_q     <= '0;
      busdata_out_q <= '0;
    end else begin
      od_q          <= od_d;
      // Open drain: a high request releases the pad instead of driving it.
      pin_out_q     <= iodatafromhm3 & ~od_q;
      pin_oe_q      <= oe & ~(od_q & iodatafromhm3);
      vld_pipe_q    <= {vld_pipe_q[0], read_reg};
      if (read_reg) rd_addr_q <= busaddress;
      if (vld_pipe_q[0]) busdata_out_q <= rdata;
    end
  end

  // Muxed one cycle after capture, so a same-cycle write is already committed.
  always_comb begin
    rd_vec = '0;
    case (bank_of(rd_addr_q))
      BK_PORT: rd_vec = port_s2;
      BK_DDR:  rd_vec = oe;
      BK_OD:   rd_vec = od_q;
      BK_CHG:  rd_vec = chg_vec;
      default: rd_vec = '0;
    endcase
    rdata = word_hit(rd_addr_q) ? BusWidth'(word_of_vec(rd_vec, rd_addr_q[0])) : '0;
  end

`ifdef GPIO_CHANGE_IRQ_EN
  gpio_vec_t prev_q, status_q, status_d, clr_vec;
  logic      irq_q;

  // New edges are OR-ed in after the clear, so a set beats a simultaneous clear.
  assign clr_vec  = (wr_hit && wr_bank == BK_CHG) ? wr_vec : '0;
  assign status_d = (status_q & ~clr_vec) | (port_s2 ^ prev_q);

  always_ff @(posedge CLOCK or negedge reset_reg_N) begin
    if (!reset_reg_N) begin
      prev_q   <= '0;
      status_q <= '0;
      irq_q    <= 1'b0;
    end else begin
      prev_q   <= port_s2;
      status_q <= status_d;
      irq_q    <= |status_q;
    end
  end

  assign chg_vec = status_q;
  assign irq     = irq_q;
`else
  assign chg_vec = '0;
  assign irq     = 1'b0;
`endif

  assign busdata_out = busdata_out_q;
  assign read_valid  = vld_pipe_q[1];
  assign pin_out     = pin_out_q;
  assign pin_oe      = pin_oe_q;
endmodule

// File: tb/tb_gpio_pin_io_reg.sv
// Randomized scoreboard bench for gpio_pin_io_reg; honours `define GPIO_CHANGE_IRQ_EN.
module tb_gpio_pin_io_reg;
  logic        CLOCK = 1'b0, reset_reg_N = 1'b0, write_reg = 1'b0, read_reg = 1'b0;
  logic [11:0] busaddress = '0;
  logic [31:0] busdata_in = '0, busdata_out;
  logic        read_valid, irq;
  logic [33:0] oe = '0, iodatafromhm3 = '0, pin_in = '0, pin_out, pin_oe;

  gpio_pin_io_reg dut (
    .CLOCK(CLOCK), .reset_reg_N(reset_reg_N), .write_reg(write_reg), .read_reg(read_reg),
    .busaddress(busaddress), .busdata_in(busdata_in), .busdata_out(busdata_out),
    .read_valid(read_valid), .oe(oe), .iodatafromhm3(iodatafromhm3), .pin_in(pin_in),
    .pin_out(pin_out), .pin_oe(pin_oe), .irq(irq)
  );

  always #5 CLOCK = ~CLOCK;

  typedef struct { logic [31:0] data; int cyc; } rd_exp_t;
  typedef struct { logic [33:0] po; logic [33:0] poe; int cyc; } pin_exp_t;

  int checks = 0, failures = 0, cyc = 0;
  rd_exp_t  rdq[$];
  pin_exp_t pinq[$];
  logic [33:0] pin_hist [0:8191];
  logic [33:0] od_m = '0, chg_m = '0, pin_v = '0, oe_v = '0, hm3_v = '0;
  logic        pend = 1'b0;
  logic [15:0] pend_a = '0;

  always @(posedge CLOCK) cyc <= cyc + 1;
  always @(negedge CLOCK) pin_hist[cyc % 8192] = pin_in;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // Register map model: bank by byte address, word 0 = pins 0..23, word 1 = pins 24..33.
  function automatic logic [31:0] exp_read(input logic [15:0] ba, input logic [33:0] port,
                                           input logic [33:0] ddr, input logic [33:0] od,
                                           input logic [33:0] chg);
    int          base, off;
    logic [33:0] v;
    base = (int'(ba) / 256) * 256;
    off  = int'(ba) % 256;
    v    = '0;
    if (base == 'h1000) v = port;
    else if (base == 'h1100) v = ddr;
    else if (base == 'h1300) v = od;
    else if (base == 'h1400) v = chg;
    if (off == 0) return {8'h0, v[23:0]};
    if (off == 4) return {22'h0, v[33:24]};
    return 32'h0;
  endfunction

  task automatic step(input logic rd, input logic wr, input logic [15:0] ba, input logic [31:0] wd);
    int       c;
    rd_exp_t  re;
    pin_exp_t pe;
    @(posedge CLOCK);
    #1;
    c = cyc;
    read_reg = rd; write_reg = wr; busaddress = ba[13:2]; busdata_in = wd;
    pin_in = pin_v; oe = oe_v; iodatafromhm3 = hm3_v;
    if (pend) begin
      re.data = exp_read(pend_a, pin_hist[(c - 2) % 8192], oe_v, od_m, chg_m);
      re.cyc  = c + 1;
      rdq.push_back(re);
    end
    for (int i = 0; i < 34; i++) begin
      pe.po[i]  = od_m[i] ? 1'b0 : hm3_v[i];
      pe.poe[i] = oe_v[i] && !(od_m[i] && hm3_v[i]);
    end
    pe.cyc = c + 1;
    pinq.push_back(pe);
    if (wr) begin
      if (ba == 16'h1300)      od_m[23:0]   = wd[23:0];
      else if (ba == 16'h1304) od_m[33:24]  = wd[9:0];
      else if (ba == 16'h1400) chg_m[23:0]  = chg_m[23:0] & ~wd[23:0];
      else if (ba == 16'h1404) chg_m[33:24] = chg_m[33:24] & ~wd[9:0];
    end
    pend = rd; pend_a = ba;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 1'b0, 16'h0, 32'h0);
  endtask

  always @(negedge CLOCK) begin : monitor
    rd_exp_t  e;
    pin_exp_t p;
    if (reset_reg_N) begin
      if (read_valid) begin
        if (rdq.size() == 0) check("read_valid_spurious", 64'(read_valid), 64'd0);
        else begin
          e = rdq.pop_front();
          check("read_latency", 64'(cyc), 64'(e.cyc));
          check("read_data", 64'(busdata_out), 64'(e.data));
        end
      end else if (rdq.size() != 0 && rdq[0].cyc <= cyc) begin
        e = rdq.pop_front();
        check("read_valid_missing", 64'(read_valid), 64'd1);
      end
      while (pinq.size() != 0 && pinq[0].cyc < cyc) void'(pinq.pop_front());
      if (pinq.size() != 0 && pinq[0].cyc == cyc) begin
        p = pinq.pop_front();
        check("pin_out", 64'(pin_out), 64'(p.po));
        check("pin_oe", 64'(pin_oe), 64'(p.poe));
      end
    end
  end

  initial begin
    logic [15:0] addrs [0:11];
    logic [63:0] r64;
    logic [15:0] a;
    logic        rd, wr;
    addrs = '{16'h1000, 16'h1004, 16'h1100, 16'h1104, 16'h1300, 16'h1304,
              16'h1400, 16'h1404, 16'h1308, 16'h1014, 16'h1200, 16'h0000};

    repeat (3) @(posedge CLOCK);
    #1;
    check("rst_pin_oe", 64'(pin_oe), 64'd0);
    check("rst_pin_out", 64'(pin_out), 64'd0);
    check("rst_busdata_out", 64'(busdata_out), 64'd0);
    check("rst_read_valid", 64'(read_valid), 64'd0);
    check("rst_irq", 64'(irq), 64'd0);
    reset_reg_N = 1'b1;
    idle(3);

    // OD write/read, then same-cycle read+write returns the new value
    step(1'b0, 1'b1, 16'h1300, 32'hFF00000F);
    step(1'b1, 1'b0, 16'h1300, 32'h0);
    idle(3);
    step(1'b1, 1'b1, 16'h1300, 32'h00ABCDEF);
    idle(3);

    // open-drain pin behaviour
    oe_v = '1; hm3_v = 34'h1;
    idle(3);
    hm3_v = '0;
    idle(3);

    // reset with a read in flight
    step(1'b1, 1'b0, 16'h1300, 32'h0);
    @(posedge CLOCK);
    #1;
    reset_reg_N = 1'b0; read_reg = 1'b0; write_reg = 1'b0;
    #1;
    check("midrst_pin_oe", 64'(pin_oe), 64'd0);
    check("midrst_busdata_out", 64'(busdata_out), 64'd0);
    check("midrst_read_valid", 64'(read_valid), 64'd0);
    rdq.delete(); pinq.delete(); pend = 1'b0; od_m = '0; chg_m = '0;
    repeat (2) @(posedge CLOCK);
    #1;
    reset_reg_N = 1'b1;
    idle(4);

    // PORT through the synchronizer, back-to-back reads
    pin_v = 34'h2_0000_0001;
    idle(3);
    step(1'b1, 1'b0, 16'h1000, 32'h0);
    step(1'b1, 1'b0, 16'h1004, 32'h0);
    idle(3);

    // writes to RO and unmapped locations are ignored
    oe_v = 34'h2_5A5A_A5A5;
    step(1'b0, 1'b1, 16'h1100, 32'h00FFFFFF);
    step(1'b0, 1'b1, 16'h1308, 32'h00000123);
    step(1'b1, 1'b0, 16'h1100, 32'h0);
    step(1'b1, 1'b0, 16'h1104, 32'h0);
    step(1'b1, 1'b0, 16'h1308, 32'h0);
    idle(3);

`ifdef GPIO_CHANGE_IRQ_EN
    step(1'b0, 1'b1, 16'h1400, 32'h00FFFFFF);
    step(1'b0, 1'b1, 16'h1404, 32'h000003FF);
    chg_m = '0;
    idle(3);
    check("irq_after_clear_all", 64'(irq), 64'd0);
    pin_v[5] = ~pin_v[5];
    idle(6);
    chg_m[5] = 1'b1;
    check("irq_on_change", 64'(irq), 64'd1);
    step(1'b1, 1'b0, 16'h1400, 32'h0);
    idle(3);
    step(1'b0, 1'b1, 16'h1400, 32'h00000020);
    idle(3);
    check("irq_after_w1c", 64'(irq), 64'd0);
    pin_v[5] = ~pin_v[5];
    idle(2);
    step(1'b0, 1'b1, 16'h1400, 32'h00000020);
    chg_m[5] = 1'b1;
    idle(3);
    check("irq_set_beats_clear", 64'(irq), 64'd1);
    step(1'b1, 1'b0, 16'h1400, 32'h0);
    idle(3);
`else
    pin_v = ~pin_v;
    idle(5);
    step(1'b1, 1'b0, 16'h1400, 32'h0);
    step(1'b1, 1'b0, 16'h1404, 32'h0);
    idle(3);
    check("irq_disabled", 64'(irq), 64'd0);
`endif

    for (int i = 0; i < 300; i++) begin
      a  = addrs[$urandom_range(0, 11)];
      rd = ($urandom_range(0, 2) != 0);
      wr = ($urandom_range(0, 2) == 0);
`ifdef GPIO_CHANGE_IRQ_EN
      if (a[15:8] == 8'h14) rd = 1'b0;
`endif
      if ($urandom_range(0, 3) == 0) begin
        r64 = {$urandom(), $urandom()};
        pin_v = r64[33:0];
      end
      r64 = {$urandom(), $urandom()};
      oe_v = r64[33:0];
      r64 = {$urandom(), $urandom()};
      hm3_v = r64[33:0];
      r64 = {$urandom(), $urandom()};
      step(rd, wr, a, r64[31:0]);
    end
    idle(5);
    check("read_queue_drained", 64'(rdq.size()), 64'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
